unshift: RTL
============

# unshift

Serial-to-parallel collector for the 8-word shift interface. Accepts one WIDTH-bit word per qualified cycle, places word k in slot k of a WIDTH*8 frame, and publishes the full frame with a one-cycle done pulse after the eighth word. It sits at the receive end of the word stream, where the upstream shifter's busy output drives `i_vld` and its data output drives `i_data`.

## Interface
- `WIDTH`, 8, word width in bits. Frame width is WIDTH*8.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  WIDTH  incoming word, sampled when `i_vld`=1.
- `i_vld`  in  1  word-valid qualifier, active-high.
- `i_clr_n`  in  1  synchronous frame abort, active-low.
- `o_data`  out  WIDTH*8  last completed frame; word k at bits [WIDTH*(k+1)-1 : WIDTH*k].
- `o_done`  out  1  one-cycle pulse; `o_data` has just been updated.
- `o_busy`  out  1  high while a partial frame is held (1–7 words captured).
- `o_cnt`  out  3  number of words captured in the current partial frame.

## Operation
- Reset (asynchronous, `rst_n`=0): state IDLE, counter 0, assembly register 0, `o_data`=0, `o_done`=0, `o_busy`=0, `o_cnt`=0.
- Two-state FSM:
  - IDLE: counter 0.
    - `i_vld`=1 and `i_clr_n`=1: write `i_data` into slot 0, set counter to 1, go to COLLECT.
  - COLLECT:
    - `i_vld`=1: write `i_data` into slot[counter].
      - counter<7: counter+1.
      - counter==7: load `o_data` with the assembly register, with slot 7 taken directly from `i_data` in the same cycle. Pulse `o_done`, clear counter, go to IDLE.
    - `i_vld`=0: hold. Gaps of any length are allowed; no timeout.
- Abort: `i_clr_n`=0 overrides `i_vld` in either state. Next state IDLE, counter 0, partial frame discarded. `o_data` unchanged, no `o_done`.
- Slot indexing: slot k occupies bits [WIDTH*(k+1)-1 : WIDTH*k]. Word 0 lands in the LSBs, matching the transmit order of the shifter.
- `o_data` changes only on frame completion and holds between frames. Stale slots in the assembly register are never observable.
- `o_busy` = (state==COLLECT). `o_cnt` = counter.
- `o_done` is registered, so it is high exactly one cycle per completed frame.

## Timing
- The word is captured at the rising edge where `i_vld`=1.
- Latency: for the eighth word captured at edge N, `o_data` and `o_done` are valid from edge N through edge N+1. `o_done` deasserts after edge N+1 unless another frame completes at that edge, which requires 8 words and so cannot happen.
- Back-to-back frames: IDLE accepts word 0 in the cycle immediately after completion. A continuous `i_vld` for 16 cycles yields two frames, with `o_done` pulses 8 cycles apart.
- Minimum frame time is 8 cycles. Maximum throughput is one word per cycle.
- If `i_clr_n`=0 in the same cycle as the eighth word, the abort wins: no `o_done`, `o_data` is unchanged.
- If reset is asserted mid-frame, all state clears immediately; the first word after reset release is treated as word 0.

## Test plan
- Reset check: assert `rst_n`=0 for 2 cycles, then release. Require `o_data`=0, `o_done`=0, `o_busy`=0, `o_cnt`=0.
- Basic frame (WIDTH=8): `i_vld`=1 for 8 cycles with `i_data`=0x11,0x22,…,0x88. Require:
  - `o_cnt` steps 1..7;
  - `o_busy`=1 for 7 cycles;
  - a single `o_done` pulse after the 8th edge;
  - `o_data`=0x8877665544332211.
- Gapped frame: the same 8 words with `i_vld`=0 for 3 cycles after words 2 and 5. Require the same `o_data`, `o_done` after the 8th valid word only, and `o_cnt` held during the gaps.
- Back-to-back: 16 consecutive valid words 0x00..0x0F. Require:
  - first frame `o_data`=0x0706050403020100;
  - second frame 0x0F0E0D0C0B0A0908;
  - `o_done` pulses exactly 8 cycles apart.
- Abort: send 5 words, pulse `i_clr_n`=0 for 1 cycle, then send 8 words 0xA0..0xA7. Require `o_cnt`=0 after the abort, no `o_done` from the aborted frame, and the final `o_data`=0xA7A6A5A4A3A2A1A0.
- Abort on the last word: assert `i_clr_n`=0 together with the 8th valid word. Require no `o_done`, `o_data` equal to the previous frame, and state IDLE.

Source files
------------

// File: rtl/unshift.sv
// -----------------------------------------------------------------------------
// unshift -- serial-to-parallel frame collector
//
// Collects eight WIDTH-bit words, one per cycle in which i_vld is high, into a
// WIDTH*8 frame. Word k lands in bits [WIDTH*(k+1)-1 : WIDTH*k], so word 0 is
// in the LSBs. After the eighth word the frame is published on o_data and
// o_done pulses for one cycle. i_clr_n low discards any partial frame.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_data   in   incoming word, sampled when i_vld = 1
//   i_vld    in   word-valid qualifier
//   i_clr_n  in   synchronous frame abort, active-low (overrides i_vld)
//   o_data   out  last completed frame (holds between frames)
//   o_done   out  one-cycle pulse when o_data has just been updated
//   o_busy   out  high while a partial frame (1..7 words) is held
//   o_cnt    out  number of words captured in the current partial frame
// -----------------------------------------------------------------------------
module unshift #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_vld,
    input  logic                 i_clr_n,
    output logic [WIDTH*8-1:0]   o_data,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [2:0]           o_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q,   cnt_d;
    logic [WIDTH*8-1:0]     asm_q,   asm_d;
    logic [WIDTH*8-1:0]     data_q,  data_d;
    logic                   done_q,  done_d;

    // State register: FSM state, word counter, assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            asm_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: abort always returns to IDLE; the eighth word closes
    // the frame and returns to IDLE so word 0 of the next frame is accepted
    // in the very next cycle.
    always_comb begin
        state_d = state_q;
        if (!i_clr_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_vld) begin
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (i_vld && (cnt_q == 3'd7)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath / output logic: slot writes, counter, frame publish, done pulse.
    // The counter is 0 in IDLE, so "write slot[cnt]" covers slot 0 there too.
    // Stale slots left in asm_q are harmless: all eight are rewritten before
    // the next publish.
    always_comb begin
        cnt_d  = cnt_q;
        asm_d  = asm_q;
        data_d = data_q;
        done_d = 1'b0;
        if (!i_clr_n) begin
            cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_vld) begin
                        asm_d[WIDTH-1:0] = i_data;
                        cnt_d            = 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                    end
                end
                ST_COLLECT: begin
                    if (i_vld) begin
                        asm_d[cnt_q*WIDTH +: WIDTH] = i_data;
                        if (cnt_q == 3'd7) begin
                            // Slot 7 bypasses the assembly register so the
                            // frame is published in the same cycle.
                            data_d = {i_data, asm_q[WIDTH*7-1:0]};
                            done_d = 1'b1;
                            cnt_d  = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    cnt_d = 3'd0;
                end
            endcase
        end
    end

    assign o_data = data_q;
    assign o_done = done_q;
    assign o_busy = (state_q == ST_COLLECT);
    assign o_cnt  = cnt_q;

endmodule
